// File: rtl/mux_pkg.sv
// Shared definitions for the N-input registered selector.
package mux_pkg;

    // Select-source encodings for the MODE parameter.
    localparam int unsigned MUX_EXT_SEL     = 0;
    localparam int unsigned MUX_FIXED_PRI   = 1;
    localparam int unsigned MUX_ROUND_ROBIN = 2;

    // Ceiling log2, never less than 1 so index ports always have a bit.
    function automatic int unsigned mux_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr wins (wraps modulo N).
// With ptr tied to zero it degenerates to fixed lowest-index priority.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = mux_clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic [SELW-1:0] idx;
    logic            found;

    // Walk ptr, ptr+1, ... wrapping, and take the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = SELW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-input registered selector with valid/ready handshakes. The select source
// (external, fixed priority or round-robin) is fixed at elaboration.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = MUX_EXT_SEL,
    parameter int unsigned SELW  = mux_clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]      in_ready,
    input  logic [SELW-1:0]   sel,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [SELW-1:0]   out_sel,
    input  logic              out_ready
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;

    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             load;
    logic             any_grant;

    // The output register can take a word when empty or being drained.
    assign load      = ~out_valid_q | out_ready;
    assign any_grant = |grant;
    assign in_ready  = grant & {N{load}};

    if (MODE == MUX_EXT_SEL) begin : g_ext
        // External select: an out-of-range sel matches no channel, so never grants.
        always_comb begin
            grant = '0;
            for (int unsigned i = 0; i < N; i++) begin
                grant[i] = in_valid[i] && (32'(sel) == i);
            end
        end
        assign grant_idx = sel;
    end else begin : g_arb
        logic [SELW-1:0] arb_ptr;
        logic            unused_sel;
        assign unused_sel = ^sel;

        if (MODE == MUX_ROUND_ROBIN) begin : g_rr
            logic [SELW-1:0] ptr_q;

            // Pointer advances past the winner only on an actual transfer.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ptr_q <= '0;
                end else if (load && any_grant) begin
                    ptr_q <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
                end
            end
            assign arb_ptr = ptr_q;
        end else begin : g_pri
            assign arb_ptr = '0;
        end

        rr_arbiter #(
            .N    (N),
            .SELW (SELW)
        ) u_rr_arbiter (
            .req       (in_valid),
            .ptr       (arb_ptr),
            .grant     (grant),
            .grant_idx (grant_idx)
        );
    end

    // Output pipeline register: load on grant, empty on idle load, hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (load) begin
            if (any_grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data[32'(grant_idx)*WIDTH +: WIDTH];
                out_sel_q   <= grant_idx;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
